// File: rtl/fft64_bitrev_reorder_if.sv
// Stream interface of the FFT output reorder buffer: bit-reversed input side,
// natural-order output side and the resync error pulse.
interface fft64_bitrev_reorder_if #(
  parameter int WIDTH = 17,
  parameter int LOG2N = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sof;
  logic signed [WIDTH-1:0] in_re;
  logic signed [WIDTH-1:0] in_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;
  logic [LOG2N-1:0]        out_idx;
  logic                    out_sof;
  logic                    out_eof;
  logic                    frame_err;

  modport slave (
    input  in_valid, in_sof, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_sof, out_eof, frame_err
  );

  modport master (
    output in_valid, in_sof, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_sof, out_eof, frame_err
  );
endinterface

// File: rtl/fft64_bitrev_reorder.sv
// Ping-pong reorder buffer: writes the SDF FFT output at bit-reversed addresses
// and streams bins out in natural order at one sample per cycle.
module fft64_bitrev_reorder #(
  parameter int WIDTH = 17,
  parameter int LOG2N = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  fft64_bitrev_reorder_if.slave io
);
  localparam int N = 1 << LOG2N;

  logic signed [WIDTH-1:0] mem_re [2*N];
  logic signed [WIDTH-1:0] mem_im [2*N];

  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic             wr_fire;
  logic             resync;
  logic             wr_last;
  logic             rd_load;
  logic             rd_last;
  logic [LOG2N-1:0] wr_addr;

  logic                    vld_p1;
  logic signed [WIDTH-1:0] re_p1;
  logic signed [WIDTH-1:0] im_p1;
  logic [LOG2N-1:0]        idx_p1;
  logic                    sof_p1;
  logic                    eof_p1;
  logic                    err_p1;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign io.in_ready = !full[wr_bank];
  assign wr_fire     = io.in_valid && !full[wr_bank];
  // A start-of-frame mid-frame restarts the current bank; the sample becomes position 0.
  assign resync      = wr_fire && io.in_sof && (wr_cnt != '0);
  assign wr_last     = wr_fire && !resync && (wr_cnt == '1);
  assign wr_addr     = resync ? '0 : bitrev(wr_cnt);
  assign rd_load     = (!vld_p1 || io.out_ready) && full[rd_bank];
  assign rd_last     = rd_load && (rd_cnt == '1);

  // Set and clear always target different banks: the write bank is never full.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  // stage p0: buffer write
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_re[{wr_bank, wr_addr}] <= io.in_re;
      mem_im[{wr_bank, wr_addr}] <= io.in_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        if (resync) begin
          wr_cnt <= LOG2N'(1);
        end else if (wr_cnt == '1) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + LOG2N'(1);
        end
      end
      if (rd_load) begin
        rd_cnt <= rd_cnt + LOG2N'(1);
        if (rd_last) rd_bank <= ~rd_bank;
      end
    end
  end

  // stage p1: registered natural-order output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      re_p1  <= '0;
      im_p1  <= '0;
      idx_p1 <= '0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= resync;
      if (rd_load) begin
        vld_p1 <= 1'b1;
        re_p1  <= mem_re[{rd_bank, rd_cnt}];
        im_p1  <= mem_im[{rd_bank, rd_cnt}];
        idx_p1 <= rd_cnt;
        sof_p1 <= (rd_cnt == '0);
        eof_p1 <= (rd_cnt == '1);
      end else if (io.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign io.out_valid = vld_p1;
  assign io.out_re    = re_p1;
  assign io.out_im    = im_p1;
  assign io.out_idx   = idx_p1;
  assign io.out_sof   = sof_p1;
  assign io.out_eof   = eof_p1;
  assign io.frame_err = err_p1;
endmodule

// File: doc/fft64_bitrev_reorder.md
Name: fft64_bitrev_reorder

Overview:
- Output end of the 64-point radix-2 SDF FFT pipeline; consumes the final PE stage's stream.
- That stream arrives in bit-reversed order; this block writes it into a ping-pong buffer at bit-reversed addresses and reads it out in natural order (bin 0..N-1).
- Valid/ready handshake on both sides; sustains 1 sample/cycle with no bubbles between frames.

Parameters:
- WIDTH, 17, bit width of each real/imag sample (final PE output width).
- LOG2N, 6, log2 of frame length; N = 2^LOG2N = 64.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_sof  in  1  marks the first sample of an input frame; qualified by in_valid.
- in_re  in  WIDTH  input sample, real part (two's complement).
- in_im  in  WIDTH  input sample, imaginary part.
- out_valid  out  1  output sample valid (registered).
- out_ready  in  1  downstream accepts.
- out_re  out  WIDTH  output bin, real part (registered).
- out_im  out  WIDTH  output bin, imaginary part (registered).
- out_idx  out  LOG2N  bin index of the current output sample.
- out_sof  out  1  high with bin 0.
- out_eof  out  1  high with bin N-1.
- frame_err  out  1  one-cycle pulse on a resync discard.

Behaviour:
- Storage: two banks of N entries (re, im). Memory is not reset.
- State: wr_bank, wr_cnt[LOG2N-1:0], rd_bank, rd_cnt[LOG2N-1:0], full[1:0].
- Reset values: all state 0; out_valid, out_re, out_im, out_idx, out_sof, out_eof, frame_err all 0.
- in_ready = !full[wr_bank] (combinational from state only, not from in_valid).
- Write handshake (in_valid && in_ready):
  - Store the sample at bank[wr_bank][bitrev(wr_cnt)]; wr_cnt increments.
  - At wr_cnt == N-1: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- bitrev: reverse the LOG2N bits (e.g. 1 -> 32, 3 -> 48).
- Resync: in_valid && in_sof with wr_cnt != 0, accepted:
  - Partial frame discarded; the sample is written at address 0; wr_cnt <= 1; frame_err pulses.
  - in_sof with wr_cnt == 0 is normal.
  - in_sof is otherwise ignored; frames without in_sof are accepted.
- Output load condition: (!out_valid || out_ready) && full[rd_bank].
  - On load: out_re/out_im <= bank[rd_bank][rd_cnt]; out_idx <= rd_cnt; out_sof <= (rd_cnt == 0); out_eof <= (rd_cnt == N-1); out_valid <= 1; rd_cnt increments.
  - When the loaded rd_cnt == N-1: clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
- If out_valid && out_ready and no load occurs: out_valid <= 0.
- If out_valid && !out_ready: all output registers hold.
- Latency: the N-th input handshake at edge E0 sets full; bin 0 is presented on out_* after E0+1.
- Simultaneous set and clear of full on different banks in the same cycle: both take effect.
  - Same-bank conflict is impossible, since the write bank is never full.
- Both banks full: in_ready = 0 until the read side frees a bank. This is the edge loading bin N-1; in_ready rises the cycle after.
- Throughput: with out_ready held 1 and in_valid held 1, output is continuous across frame boundaries with no gap.
- Mid-operation reset: all buffered frames are lost; out_valid drops immediately (asynchronous).
- No arithmetic: data passes bit-exact; no width change.

Test Plan:
- Single frame: in_re = p (arrival position 0..63), in_im = -p, out_ready = 1 -> out_re sequence 0,32,16,48,8,40,...,63 (out_re[k] = bitrev(k)); out_idx 0..63; out_sof on first, out_eof on last; first out_valid one cycle after 64th input.
- Back-to-back: 3 frames, in_valid and out_ready held 1 -> 192 consecutive out_valid cycles, no gap; in_ready never drops.
- Backpressure: out_ready = 0 throughout, 128+ samples offered -> in_ready falls after exactly 128 accepts. Then raise out_ready -> in_ready rises the cycle after bin 63 of frame 0 loads.
- Stall hold: drop out_ready while bin 5 is presented for 3 cycles -> out_re/out_im/out_idx stable; no bin lost or duplicated.
- Resync: assert in_sof on the 20th sample -> frame_err pulses once; the next 64 accepted samples (starting with that one) form the output frame; the partial data never appears.
- Reset mid-frame: rst_n low for 2 cycles after 40 samples -> out_valid 0, in_ready 1. A following full frame outputs correctly with no stale data.
